// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall, branch-flush and forwarding control for the in-order pipeline
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [NSRC*ADDR_W-1:0] id_src_addr_i,
    input  logic [NSRC-1:0]        id_src_used_i,
    input  logic [ADDR_W-1:0]      id_dst_addr_i,
    input  logic                   id_reg_write_i,
    input  logic                   id_is_load_i,
    input  logic                   id_is_branch_i,
    input  logic                   id_branch_taken_i,
    output logic                   stall_o,
    output logic                   flush_o,
    output logic [NSRC*FW-1:0]     fwd_sel_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);
    logic [DEPTH-1:0]  e_v, e_wr, e_ld;
    logic [ADDR_W-1:0] e_dst [DEPTH];
    logic [NSRC-1:0]   lu;
    logic              br_hit, issue;
    logic [NSRC*FW-1:0] fwd_nxt;
    logic [ADDR_W-1:0] src;
    logic              found, hit;
    int                yk;
    // youngest-match search per operand; loads too young to forward stall, branches stall on anything not yet written back
    always_comb begin
        lu      = '0;
        br_hit  = 1'b0;
        fwd_nxt = '0;
        src     = '0;
        found   = 1'b0;
        hit     = 1'b0;
        yk      = 0;
        for (int n = 0; n < NSRC; n++) begin
            src   = id_src_addr_i[n*ADDR_W +: ADDR_W];
            found = 1'b0;
            yk    = 0;
            for (int k = DEPTH-1; k >= 0; k--) begin
                hit = e_v[k] && e_wr[k] && e_dst[k] == src && src != '0 && id_src_used_i[n];
                if (hit) begin
                    found = 1'b1;
                    yk    = k;
                    if (k <= DEPTH-2) br_hit = 1'b1;
                end
            end
            lu[n] = found && e_ld[yk] && (yk + 1 < LOAD_READY);
            fwd_nxt[n*FW +: FW] = (found && yk + 1 <= DEPTH-1) ? FW'(yk + 1) : '0;
        end
    end
    assign stall_o = !rst_i && id_valid_i && (|lu || (id_is_branch_i && br_hit));
    assign flush_o = !rst_i && id_valid_i && id_is_branch_i && id_branch_taken_i && !stall_o;
    assign issue   = id_valid_i && !stall_o;
    // shift the scoreboard, register forwarding selects and update saturating counters
    always_ff @(posedge clk_i) begin
        e_wr     <= {e_wr[DEPTH-2:0], id_reg_write_i};
        e_ld     <= {e_ld[DEPTH-2:0], id_is_load_i};
        e_dst[0] <= id_dst_addr_i;
        for (int k = 1; k < DEPTH; k++) e_dst[k] <= e_dst[k-1];
        if (rst_i) begin
            e_v         <= '0;
            fwd_sel_o   <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            e_v         <= {e_v[DEPTH-2:0], issue};
            fwd_sel_o   <= issue ? fwd_nxt : '0;
            stall_cnt_o <= stall_cnt_o + CNT_W'(stall_o && !(&stall_cnt_o));
            flush_cnt_o <= flush_cnt_o + CNT_W'(flush_o && !(&flush_cnt_o));
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order pipeline. It replaces the fixed one-cycle load-use detector with a shadow scoreboard of in-flight destination registers over DEPTH post-ID stages. From the scoreboard it produces the stall, branch-flush and registered per-operand forwarding selects consumed by EX. It also keeps saturating stall and flush counters for performance analysis.

Parameters:
ADDR_W, 5, register address width; address 0 is hardwired zero and never matches.
DEPTH, 3, tracked stages after ID: entry 0 = EX, entry DEPTH-1 = WB; DEPTH >= 2.
NSRC, 2, source operands per instruction.
LOAD_READY, 2, lowest entry index from which load data is forwardable; 1 <= LOAD_READY <= DEPTH-1.
CNT_W, 16, performance counter width.
FW, $clog2(DEPTH), forwarding-select width (derived; not overridden).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  ID holds a real instruction
id_src_addr_i  in  NSRC*ADDR_W  source register addresses; operand n at [n*ADDR_W +: ADDR_W]
id_src_used_i  in  NSRC  operand n is actually read
id_dst_addr_i  in  ADDR_W  destination register
id_reg_write_i  in  1  instruction writes the register file
id_is_load_i  in  1  destination value comes from data memory
id_is_branch_i  in  1  instruction compares operands in ID
id_branch_taken_i  in  1  ID branch comparison result
stall_o  out  1  hold PC and IF/ID; bubble into EX (combinational)
flush_o  out  1  squash IF/ID (combinational)
fwd_sel_o  out  NSRC*FW  registered per-operand select for EX: 0 = ID/EX register data, j = result of stage entry j
stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating
flush_cnt_o  out  CNT_W  cycles with flush_o=1, saturating

Behaviour:
- Scoreboard entry fields: valid, wr, is_load, dst. Entry k matches source s when valid, wr, dst==s, s!=0, and the operand's used bit is set.
- Each cycle: entry[k+1] <= entry[k]; the oldest entry drops out.
- Entry 0 <= ID instruction if id_valid_i && !stall_o; otherwise entry 0 <= bubble (valid=0).
- The youngest match (smallest k) decides. The consumer reaches EX next cycle, when the producer is at j = k+1.
- Load-use stall: youngest match is a load with k+1 < LOAD_READY.
- Branch stall: id_is_branch_i and any match in entries 0..DEPTH-2. The register file write-through covers entry DEPTH-1.
- stall_o = id_valid_i && (any load-use stall || branch stall). It is combinational.
- flush_o = id_valid_i && id_is_branch_i && id_branch_taken_i && !stall_o. Stall has priority, and an unresolved branch never flushes.
- fwd_sel_o for operand n is registered at the same edge that loads entry 0:
  - j = k+1 if a match exists and k+1 <= DEPTH-1;
  - 0 otherwise, including no match, producer leaving the table, a bubble, or a stall.
- Counters increment by 1 per asserted cycle and hold at 2^CNT_W-1.
- Reset (synchronous): all entries invalid, fwd_sel_o=0, both counters 0. stall_o and flush_o are 0 while rst_i=1.
- Reset mid-stall clears the scoreboard, so the stalled instruction proceeds with no stall on the next cycle.

Test Plan:
(DEPTH=3, LOAD_READY=2 unless stated.)
1. ALU writes r5, next cycle consumer reads r5 in src0 -> stall_o=0; fwd_sel src0=1 in consumer's EX cycle. With one intervening instruction -> fwd_sel=2. With two -> fwd_sel=0.
2. Load to r8, next instruction reads r8 in src1 -> stall_o=1 for exactly 1 cycle, bubble inserted, then fwd_sel src1=2. Same with LOAD_READY=1 -> no stall, fwd_sel=1.
3. Producers to r3 at entries 0 and 1 (both ALU) -> youngest wins, fwd_sel=1. Consumer reading r0 with r0 producer in flight -> fwd_sel=0, no stall.
4. Branch reading r4 with ALU producer of r4 just issued -> stall 2 cycles, no flush during stall. Then taken=1 -> flush_o=1 for 1 cycle; taken=0 -> flush_o=0.
5. Assert rst_i during a load-use stall -> next cycle stall_o=0, fwd_sel_o=0, counters 0.
6. CNT_W=4, stall held 20 cycles -> stall_cnt_o saturates at 15.
